// File: rtl/bbox_check_scoreboard.sv
// Scoreboard for the rasterizer bounding-box stage.
// Recomputes the expected box and valid/cull decision from the R10 triangle,
// delays it through a halt-aware reference pipeline, and compares it with the
// DUT's R13 outputs. Emits a one-cycle error pulse plus running counters.
//
// Valid semantics: validTri_R10H qualifies tri_R10S on any cycle where
// halt_RnnnnL = 1; validTri_R13H qualifies tri_R13S/box_R13S on the same kind
// of cycle. While halt_RnnnnL = 0 nothing is captured and nothing is compared.
module bbox_check_scoreboard #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS],
  input  logic                     validTri_R10H,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic                     halt_RnnnnL,
  input  logic signed [SIGFIG-1:0] screen_RnnnnS [2],
  input  logic [3:0]               subSample_RnnnnU,
  output logic                     err_R13H,
  output logic [31:0]              check_count,
  output logic [31:0]              err_count
);

  localparam int LAST = PIPE_DEPTH - 1;

  // Colour channels travel alongside the triangle elsewhere in the pipe; here
  // they only have to be sane, and x/y must exist for a 2-D box.
  if (VERTS < 1 || AXIS < 2 || COLORS < 1 || PIPE_DEPTH < 1 || RADIX < 3) begin : g_bad_params
    $error("bbox_check_scoreboard: unsupported parameter set");
  end

  // Reference result for the current R10 triangle
  logic signed [SIGFIG-1:0] lo_x, lo_y, hi_x, hi_y;
  logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
  logic signed [SIGFIG-1:0] snap_mask;
  logic                     exp_valid;

  // Reference pipeline, stage 0 is the newest entry
  logic                     pipe_v   [PIPE_DEPTH];
  logic signed [SIGFIG-1:0] pipe_tri [PIPE_DEPTH][VERTS][AXIS];
  logic signed [SIGFIG-1:0] pipe_box [PIPE_DEPTH][2][2];

  logic data_diff;
  logic mismatch;
  logic compare_active;

  // Expected box: vertex extents, floored to the sample grid, clamped to screen
  always_comb begin
    lo_x = tri_R10S[0][0];
    hi_x = tri_R10S[0][0];
    lo_y = tri_R10S[0][1];
    hi_y = tri_R10S[0][1];
    for (int v = 1; v < VERTS; v++) begin
      if (tri_R10S[v][0] < lo_x) lo_x = tri_R10S[v][0];
      if (tri_R10S[v][0] > hi_x) hi_x = tri_R10S[v][0];
      if (tri_R10S[v][1] < lo_y) lo_y = tri_R10S[v][1];
      if (tri_R10S[v][1] > hi_y) hi_y = tri_R10S[v][1];
    end

    // Clearing low bits of a two's-complement value floors toward -inf.
    // Unknown grid codes fall back to one sample per pixel.
    snap_mask = '1;
    case (subSample_RnnnnU)
      4'b0100: snap_mask = snap_mask << (RADIX - 1);
      4'b0010: snap_mask = snap_mask << (RADIX - 2);
      4'b0001: snap_mask = snap_mask << (RADIX - 3);
      default: snap_mask = snap_mask << RADIX;
    endcase

    ll_x = lo_x & snap_mask;
    ll_y = lo_y & snap_mask;
    ur_x = hi_x & snap_mask;
    ur_y = hi_y & snap_mask;

    if (ll_x[SIGFIG-1]) ll_x = '0;
    if (ll_y[SIGFIG-1]) ll_y = '0;
    if (ur_x > screen_RnnnnS[0]) ur_x = screen_RnnnnS[0];
    if (ur_y > screen_RnnnnS[1]) ur_y = screen_RnnnnS[1];

    // An inverted box after clamping means nothing is on screen
    exp_valid = validTri_R10H && (ur_x >= ll_x) && (ur_y >= ll_y);
  end

  // Shift the reference pipeline only on unhalted cycles; data needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < PIPE_DEPTH; s++) pipe_v[s] <= 1'b0;
    end else if (halt_RnnnnL) begin
      pipe_v[0]      <= exp_valid;
      pipe_box[0][0][0] <= ll_x;
      pipe_box[0][0][1] <= ll_y;
      pipe_box[0][1][0] <= ur_x;
      pipe_box[0][1][1] <= ur_y;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          pipe_tri[0][v][a] <= tri_R10S[v][a];
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_box[s] <= pipe_box[s-1];
        pipe_tri[s] <= pipe_tri[s-1];
      end
    end
  end

  // Compare the last reference stage with what the DUT presents at R13
  always_comb begin
    data_diff = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 2; a++)
        if (box_R13S[k][a] != pipe_box[LAST][k][a]) data_diff = 1'b1;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        if (tri_R13S[v][a] != pipe_tri[LAST][v][a]) data_diff = 1'b1;
    // Box and triangle only matter when a valid triangle is expected
    mismatch       = pipe_v[LAST] ? (!validTri_R13H || data_diff) : validTri_R13H;
    compare_active = pipe_v[LAST] || validTri_R13H;
  end

  // Registered error pulse and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      err_R13H    <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
    end else if (halt_RnnnnL) begin
      err_R13H <= mismatch;
      if (compare_active && (check_count != '1)) check_count <= check_count + 32'd1;
      if (mismatch && (err_count != '1))         err_count   <= err_count + 32'd1;
    end else begin
      err_R13H <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bbox_check_scoreboard.sv
// Bench for bbox_check_scoreboard: plays the role of the bbox stage, feeding
// triangles at R10 and chosen results at R13, and predicts the scoreboard's
// pulses and counters from an independent arithmetic model.
module tb_bbox_check_scoreboard;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [23:0] tri_r10 [3][3];
  logic signed [23:0] tri_r13 [3][3];
  logic signed [23:0] box_r13 [2][2];
  logic signed [23:0] screen  [2];
  logic               v_r10 = 1'b0;
  logic               v_r13 = 1'b0;
  logic               halt_l = 1'b1;
  logic [3:0]         sub = 4'b1000;
  logic               err_R13H;
  logic [31:0]        check_count, err_count;

  bbox_check_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R10S         (tri_r10),
    .validTri_R10H    (v_r10),
    .tri_R13S         (tri_r13),
    .box_R13S         (box_r13),
    .validTri_R13H    (v_r13),
    .halt_RnnnnL      (halt_l),
    .screen_RnnnnS    (screen),
    .subSample_RnnnnU (sub),
    .err_R13H         (err_R13H),
    .check_count      (check_count),
    .err_count        (err_count)
  );

  // Model state
  typedef logic [8:0][23:0] tri_p_t;
  typedef struct packed {
    logic          v;
    logic [3:0][23:0] box;   // ll.x, ll.y, ur.x, ur.y
    tri_p_t        tri_p;
  } ent_t;

  ent_t ref_q[$];
  int   m_chk, m_err;
  bit   m_flag;
  int   scr_x = 65536, scr_y = 65536;
  int   total = 0, bad = 0;

  function automatic int floor_to(int a, int s);
    return a - (((a % s) + s) % s);
  endfunction

  // Expected box and valid decision from plain integer arithmetic
  function automatic ent_t model(tri_p_t t, bit v, logic [3:0] sb);
    int lx, hx, ly, hy, step, x, y;
    ent_t e;
    lx = int'($signed(t[0])); hx = lx;
    ly = int'($signed(t[1])); hy = ly;
    for (int i = 1; i < 3; i++) begin
      x = int'($signed(t[i*3]));
      y = int'($signed(t[i*3+1]));
      if (x < lx) lx = x;
      if (x > hx) hx = x;
      if (y < ly) ly = y;
      if (y > hy) hy = y;
    end
    case (sb)
      4'b0100: step = 512;
      4'b0010: step = 256;
      4'b0001: step = 128;
      default: step = 1024;
    endcase
    lx = floor_to(lx, step); hx = floor_to(hx, step);
    ly = floor_to(ly, step); hy = floor_to(hy, step);
    if (lx < 0) lx = 0;
    if (ly < 0) ly = 0;
    if (hx > scr_x) hx = scr_x;
    if (hy > scr_y) hy = scr_y;
    e.v = v && (hx >= lx) && (hy >= ly);
    e.box[0] = 24'(lx); e.box[1] = 24'(ly);
    e.box[2] = 24'(hx); e.box[3] = 24'(hy);
    e.tri_p = t;
    return e;
  endfunction

  function automatic tri_p_t tri_of(int x0, int y0, int x1, int y1, int x2, int y2);
    tri_p_t t;
    t = '0;
    t[0] = 24'(x0); t[1] = 24'(y0); t[2] = 24'(7);
    t[3] = 24'(x1); t[4] = 24'(y1); t[5] = 24'(-3);
    t[6] = 24'(x2); t[7] = 24'(y2); t[8] = 24'(100);
    return t;
  endfunction

  function automatic ent_t r13_of(bit v, int llx, int lly, int urx, int ury, tri_p_t t);
    ent_t e;
    e.v = v;
    e.box[0] = 24'(llx); e.box[1] = 24'(lly);
    e.box[2] = 24'(urx); e.box[3] = 24'(ury);
    e.tri_p = t;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ref_q = {};
    for (int i = 0; i < 3; i++) ref_q.push_back('0);
    m_chk = 0; m_err = 0; m_flag = 1'b0;
  endtask

  // Driver: one clock with given R10/R13 inputs, model update, output checks
  task automatic cyc(tri_p_t t10, bit v10, bit h, ent_t r13);
    ent_t e;
    bit   mm;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) begin
        tri_r10[v][a] = t10[v*3+a];
        tri_r13[v][a] = r13.tri_p[v*3+a];
      end
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 2; a++)
        box_r13[k][a] = r13.box[k*2+a];
    v_r10  = v10;
    v_r13  = r13.v;
    halt_l = h;
    @(posedge clk);
    mm = 1'b0;
    if (h) begin
      e = ref_q.pop_front();
      if (e.v) mm = !r13.v || (r13.box != e.box) || (r13.tri_p != e.tri_p);
      else     mm = r13.v;
      if (e.v || r13.v) m_chk++;
      if (mm) m_err++;
      ref_q.push_back(model(t10, v10, sub));
    end
    m_flag = mm;
    #1;
    chk("err_R13H", 32'(err_R13H), 32'(m_flag));
    chk("check_count", check_count, m_chk);
    chk("err_count", err_count, m_err);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b1, '0);
  endtask

  // Reset with R13 deliberately showing a valid triangle: no error may appear
  task automatic do_reset(int n);
    rst = 1'b1;
    v_r13 = 1'b1;
    v_r10 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_err", 32'(err_R13H), 32'd0);
      chk("rst_check_count", check_count, 32'd0);
      chk("rst_err_count", err_count, 32'd0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tri_p_t tb_tri, t;
    ent_t   r;
    int     cc_save;
    screen[0] = 24'(scr_x);
    screen[1] = 24'(scr_y);
    tri_r10 = '{default: '0};
    tri_r13 = '{default: '0};
    box_r13 = '{default: '0};
    @(negedge clk);
    do_reset(2);

    tb_tri = tri_of(1536, 2304, 11008, 3072, 4096, 9728);

    // Basic triangle, one sample per pixel
    sub = 4'b1000;
    cyc(tb_tri, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 1024, 2048, 10240, 9216, tb_tri));
    chk("basic_err", 32'(err_R13H), 32'd0);
    chk("basic_count", check_count, 32'd1);

    // Half-pixel grid, correct box then the coarse box
    sub = 4'b0100;
    cyc(tb_tri, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 1536, 2048, 10752, 9728, tb_tri));
    chk("half_err", 32'(err_R13H), 32'd0);
    cyc(tb_tri, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 1024, 2048, 10240, 9216, tb_tri));
    chk("half_wrongbox_err", 32'(err_R13H), 32'd1);
    chk("half_wrongbox_count", err_count, 32'd1);

    // Fully off-screen triangle: culled
    sub = 4'b1000;
    t = tri_of(-5000, 100, -3000, 5000, -1024, 2000);
    cyc(t, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, '0);
    chk("cull_quiet_err", 32'(err_R13H), 32'd0);
    cyc(t, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 0, 0, 0, 0, t));
    chk("cull_dut_valid_err", 32'(err_R13H), 32'd1);
    chk("cull_dut_valid_count", err_count, 32'd2);

    // Partial clip on the right edge
    t = tri_of(60000, 100, 70000, 3000, 62000, 8000);
    cyc(t, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 59392, 0, 65536, 7168, t));
    chk("clip_err", 32'(err_R13H), 32'd0);

    // Halt mid-stream; R13 shows junk while halted and must be ignored
    cyc(tb_tri, 1'b1, 1'b1, '0);
    cc_save = m_chk;
    for (int i = 0; i < 5; i++) begin
      cyc('0, 1'b1, 1'b0, r13_of(1'b1, 1, 2, 3, 4, '0));
      chk("halt_hold_count", check_count, cc_save);
    end
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 1024, 2048, 10240, 9216, tb_tri));
    chk("halt_release_err", 32'(err_R13H), 32'd0);

    // Reset with two triangles in flight
    cyc(tb_tri, 1'b1, 1'b1, '0);
    cyc(tb_tri, 1'b1, 1'b1, '0);
    do_reset(2);
    idle(3);
    cyc(tb_tri, 1'b1, 1'b1, '0);
    idle(2);
    cyc('0, 1'b0, 1'b1, r13_of(1'b1, 1024, 2048, 10240, 9216, tb_tri));
    chk("post_reset_err", 32'(err_R13H), 32'd0);
    chk("post_reset_count", check_count, 32'd1);

    // Randomized traffic: random halts, grids, triangles and R13 corruptions
    for (int n = 0; n < 500; n++) begin
      bit h, v;
      for (int i = 0; i < 9; i++) begin
        if (i % 3 == 2) t[i] = 24'($urandom_range(0, 4095));
        else            t[i] = 24'(int'($urandom_range(0, 90000)) - 10000);
      end
      case ($urandom_range(0, 4))
        0: sub = 4'b1000;
        1: sub = 4'b0100;
        2: sub = 4'b0010;
        3: sub = 4'b0001;
        default: sub = 4'($urandom_range(0, 15));
      endcase
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 7) != 0);
      if (h) begin
        r = ref_q[0];
        if (!r.v) r.box = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 9))
          0: r.v = !r.v;
          1: r.box[$urandom_range(0, 3)] ^= 24'(1 << $urandom_range(0, 23));
          2: r.tri_p[$urandom_range(0, 8)] ^= 24'(1 << $urandom_range(0, 23));
          default: ;
        endcase
      end else begin
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      cyc(t, v, h, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bbox_check_scoreboard.md
Name: bbox_check_scoreboard

Overview:
- Self-checking scoreboard for the rasterizer bounding-box stage.
- Snoops the R10 triangle input and independently computes the expected bounding box and valid/cull decision.
- Delays that result by the bbox pipeline depth, honouring halt stalls, and compares it against the DUT's R13 outputs (triangle, box, valid).
- Reports per-cycle mismatch pulses plus running check and error counters for the testbench.

Parameters:
- SIGFIG, 24, bit width of fixed-point coordinates.
- RADIX, 10, number of fraction bits (1.0 = 1<<RADIX).
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex (x, y, z).
- COLORS, 3, colour channels (for interface consistency only).
- PIPE_DEPTH, 3, cycles from R10 to R13 in the bbox stage.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- tri_R10S  input  signed SIGFIG x [VERTS][AXIS]  triangle entering bbox.
- validTri_R10H  input  1  R10 triangle valid.
- tri_R13S  input  signed SIGFIG x [VERTS][AXIS]  DUT triangle output.
- box_R13S  input  signed SIGFIG x [2][2]  DUT box; [0] = lower-left, [1] = upper-right; [.][0] = x, [.][1] = y.
- validTri_R13H  input  1  DUT output valid.
- halt_RnnnnL  input  1  active-low halt; 0 = pipeline stalled.
- screen_RnnnnS  input  signed SIGFIG x [2]  screen width/height (fixed point), static during a run.
- subSample_RnnnnU  input  4  one-hot sample grid: 1000 = 1 sample/pixel, 0100 = 1/2 pixel, 0010 = 1/4 pixel, 0001 = 1/8 pixel.
- err_R13H  output  1  mismatch flagged this cycle.
- check_count  output  32  number of R13 comparisons performed.
- err_count  output  32  number of mismatches.

Behaviour:
- Reset (synchronous, active-high):
  - All reference-pipeline valid bits cleared.
  - err_R13H = 0, check_count = 0, err_count = 0.
- Reference computation (combinational on R10 inputs):
  - llx/lly = min of vertex x/y; urx/ury = max of vertex x/y; z is ignored.
- Grid snap: floor all four values to the sample grid by clearing the low bits (two's-complement floor).
  - Bits cleared: RADIX for 1000, RADIX-1 for 0100, RADIX-2 for 0010, RADIX-3 for 0001.
  - Any other subSample code is treated as 1000.
- Clamp after snapping:
  - ll = max(ll, 0).
  - ur = min(ur, screen) per axis.
- Cull rule: expected valid = validTri_R10H AND urx >= llx AND ury >= lly after clamping. This covers fully off-screen triangles.
- Reference pipeline: PIPE_DEPTH-entry shift register of {expected valid, tri, box}.
  - Advances only on cycles with halt_RnnnnL = 1 and rst = 0.
  - Holds all contents when halt_RnnnnL = 0.
- Comparison: evaluated each cycle with halt_RnnnnL = 1, using the last stage (aligned with R13).
  - If expected valid = 1: mismatch if validTri_R13H = 0, or any box_R13S field differs, or any tri_R13S element differs.
  - If expected valid = 0: mismatch if validTri_R13H = 1. Box and tri are don't-care.
  - check_count increments when either expected valid or validTri_R13H is 1.
  - err_R13H is registered: asserted the cycle after a mismatch, for one cycle.
  - err_count increments on the same edge err_R13H is set.
- No comparison while halted or during reset. Counters saturate at 2^32-1.
- Reset mid-run flushes the pipeline; no spurious errors are raised for entries in flight.
- Simultaneous halt deassertion and new R10 input: the R10 input is captured on that edge.

Test Plan:
- Basic, RADIX = 10, subSample 1000, screen = (65536, 65536), vertices (1536,2304), (11008,3072), (4096,9728), DUT box ll (1024,2048) / ur (10240,9216), valid 3 cycles later -> err_R13H = 0, check_count = 1.
- Same triangle, subSample 0100, DUT box ll (1536,2048) / ur (10752,9728) -> no error. Same triangle with the 1000 box -> err_R13H = 1, err_count = 1.
- Off-screen triangle, all x in (-5000, -1024), DUT validTri_R13H = 0 -> no error. DUT asserts valid -> err_count increments.
- Partial-clip triangle with urx = 70000 -> expected urx = 65536; DUT box urx = 65536 -> pass.
- halt_RnnnnL held 0 for 5 cycles mid-stream -> reference holds; the DUT output after release matches; check_count is unchanged during the halt.
- Assert rst with 2 triangles in flight -> counters return to 0, no error pulses; the next triangle checks cleanly.
